accel_mem_port_scheduler: RTL and testbench
===========================================

Name: accel_mem_port_scheduler

Overview:
- Shares the single Avalon-MM master port between the accelerator's read channel (feature-map/weight fetch) and write channel (output store).
- Arbitrates between the two channels and sequences each transfer, honouring AVM_waitrequest.
- Converts word indices to byte addresses, sign-extends 16-bit results onto the 32-bit bus, and flags stalled transfers with a timeout.
- Sits between the accelerator core and the Avalon interconnect, replacing direct wiring of core memory strobes to the bus.

Parameters:
- ADDR_WIDTH, 32, width of word-index addresses from the core.
- DATA_WIDTH, 16, core data width; must be ≤ 32.
- TIMEOUT_W, 8, width of the waitrequest timeout counter.
- TIMEOUT_CYCLES, 255, max consecutive waitrequest-high cycles before abort; must be < 2^TIMEOUT_W.

Ports:
- AVS_Clk  in  1  clock
- AVS_Reset  in  1  synchronous, active-low reset
- RD_Req  in  1  read request; held until RD_Ack
- RD_Addr  in  ADDR_WIDTH  read word index
- RD_Data  out  DATA_WIDTH  read data; valid when RD_Ack=1, held until next read completes
- RD_Ack  out  1  one-cycle read completion pulse
- WR_Req  in  1  write request; held until WR_Ack
- WR_Addr  in  ADDR_WIDTH  write word index
- WR_Data  in  DATA_WIDTH  signed write data
- WR_Ack  out  1  one-cycle write completion pulse
- AVM_address  out  32  byte address
- AVM_read  out  1  Avalon read strobe
- AVM_write  out  1  Avalon write strobe
- AVM_writedata  out  32  sign-extended write data
- AVM_byteenable  out  4  constant 4'b1111
- AVM_readdata  in  32  Avalon read data
- AVM_waitrequest  in  1  Avalon stall
- Busy  out  1  high when state ≠ IDLE
- Timeout_Err  out  1  sticky timeout flag
- Clear_Err  in  1  clears Timeout_Err
- Perf_Stall_Cnt  out  32  waitrequest-stall cycle count (see optional feature)
- Perf_Xfer_Cnt  out  32  completed-transfer count (see optional feature)

Behaviour:
- Reset: one clock; reset is synchronous and active-low. On a sampled AVS_Reset=0 at any edge, including mid-transfer:
  - state←IDLE, last_grant←WR.
  - All outputs 0 (AVM_byteenable stays 4'b1111); RD_Data←0; Timeout_Err←0; counters←0.
  - An in-flight transfer is dropped with no ack.
- States:
  - IDLE: sample RD_Req/WR_Req.
    - Only one set → grant it.
    - Both set → grant the channel not equal to last_grant (round-robin). After reset the read channel wins first.
    - Granting latches address/data into a command register, updates last_grant, moves to RD_CMD or WR_CMD.
    - Neither set → stay in IDLE.
  - RD_CMD / WR_CMD: AVM_read (or AVM_write) = 1, driven from registers.
    - AVM_address = {cmd_addr[29:0], 2'b00}; upper bits are truncated when ADDR_WIDTH > 30.
    - AVM_writedata = {{(32-DATA_WIDTH){WR_Data[DATA_WIDTH-1]}}, WR_Data} as latched.
    - On an edge with AVM_waitrequest=0: read captures AVM_readdata[DATA_WIDTH-1:0] into RD_Data; both go to DONE.
    - Timeout counter resets on entry and increments each waitrequest-high cycle. When it reaches TIMEOUT_CYCLES: strobe drops, Timeout_Err←1, RD_Data←0 for a read, go to DONE (the ack still issues so the core does not hang).
  - DONE: the granted ack = 1 for exactly this cycle; strobes 0; next state IDLE.
    - Requests present during DONE are ignored, so a held request cannot double-issue.
- Minimum 3 cycles per transfer: request seen in IDLE at cycle t, strobe at t+1, ack at t+2 with zero wait.
- Strobes are never asserted in IDLE or DONE, and AVM_read and AVM_write are never high together.
- A requester dropping Req before its ack is a protocol violation. The transfer still completes and acks.
- Clear_Err=1 clears Timeout_Err; if a new timeout occurs in the same cycle, set wins.
- RD_Addr/WR_Addr/WR_Data are sampled only at grant.

Optional Feature:
- Macro ACCEL_MEM_PERF_CNT_EN.
- Defined:
  - Perf_Stall_Cnt increments every cycle in RD_CMD/WR_CMD with AVM_waitrequest=1.
  - Perf_Xfer_Cnt increments on every ack.
  - Both are 32-bit, wrap at 2^32, and clear on reset or Clear_Err.
- Undefined: both ports tied to 0 and no counter flops inferred.

Decomposition:
- Package accel_mem_pkg holds:
  - state encoding (IDLE, RD_CMD, WR_CMD, DONE);
  - channel ID constants (CH_RD, CH_WR);
  - BYTEENABLE=4'b1111;
  - WORD_SHIFT=2.
- Sub-module rr_arbiter2: two-requester round-robin with last_grant register and an enable input driven from IDLE.

Test Plan:
- Single read, waitrequest=0, RD_Addr=5, readdata=32'h0000_1234 → AVM_address=32'h14 with AVM_read for 1 cycle; RD_Ack at t+2; RD_Data=16'h1234.
- Single write, WR_Addr=3, WR_Data=16'h8001, waitrequest high 4 cycles → AVM_address=32'hC; AVM_writedata=32'hFFFF_8001 held for 5 cycles; WR_Ack one cycle after the waitrequest drop.
- RD_Req and WR_Req held high together from reset → grant order RD, WR, RD, WR; each ack a one-cycle pulse; no back-to-back double issue.
- waitrequest stuck high, TIMEOUT_CYCLES=255 → abort after 255 stall cycles; Timeout_Err=1; RD_Ack pulses with RD_Data=0; Clear_Err=1 → Timeout_Err=0.
- AVS_Reset=0 asserted during WR_CMD → next edge AVM_write=0, Busy=0, no WR_Ack; first post-reset simultaneous request grants read.
- With ACCEL_MEM_PERF_CNT_EN: three transfers totalling 7 stall cycles → Perf_Xfer_Cnt=3, Perf_Stall_Cnt=7. Without the macro, both read 0.

Source files
------------

// File: rtl/accel_mem_port_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_mem_pkg
// Description : Shared types and constants for the accelerator memory port
//               scheduler: FSM state encoding, channel IDs, bus constants and
//               the word-index to byte-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CMD = 2'd1,
    WR_CMD = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic       CH_RD      = 1'b0;
  localparam logic       CH_WR      = 1'b1;
  localparam logic [3:0] BYTEENABLE = 4'b1111;
  localparam int         WORD_SHIFT = 2;

  // Word index to byte address on the 32-bit bus; top index bits fall off.
  function automatic logic [31:0] word_to_byte(input logic [31:0] idx);
    return idx << WORD_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_mem_port_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : accel_mem_port_scheduler_if
// Description : Bundle of the core-side read/write channels and the
//               Avalon-MM master bus handled by the scheduler.
//   master : scheduler view (drives acks, RD_Data and the AVM_* strobes)
//   slave  : environment view (core requesters plus Avalon interconnect)
// Revision    : 1.0 - initial release
// ============================================================================
interface accel_mem_port_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  // Core read channel
  logic                  RD_Req;
  logic [ADDR_WIDTH-1:0] RD_Addr;
  logic [DATA_WIDTH-1:0] RD_Data;
  logic                  RD_Ack;
  // Core write channel
  logic                  WR_Req;
  logic [ADDR_WIDTH-1:0] WR_Addr;
  logic [DATA_WIDTH-1:0] WR_Data;
  logic                  WR_Ack;
  // Avalon-MM master
  logic [31:0]           AVM_address;
  logic                  AVM_read;
  logic                  AVM_write;
  logic [31:0]           AVM_writedata;
  logic [3:0]            AVM_byteenable;
  logic [31:0]           AVM_readdata;
  logic                  AVM_waitrequest;

  modport master (
    input  RD_Req, RD_Addr, WR_Req, WR_Addr, WR_Data,
           AVM_readdata, AVM_waitrequest,
    output RD_Data, RD_Ack, WR_Ack,
           AVM_address, AVM_read, AVM_write, AVM_writedata, AVM_byteenable
  );

  modport slave (
    output RD_Req, RD_Addr, WR_Req, WR_Addr, WR_Data,
           AVM_readdata, AVM_waitrequest,
    input  RD_Data, RD_Ack, WR_Ack,
           AVM_address, AVM_read, AVM_write, AVM_writedata, AVM_byteenable
  );
endinterface
`default_nettype wire

// File: rtl/accel_mem_port_scheduler_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter with a last-grant register.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   en_i          : arbitration enabled (scheduler idle)
//   req_rd_i/wr_i : channel requests
//   valid_o       : a grant is issued this cycle
//   grant_o       : granted channel (CH_RD / CH_WR)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import accel_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_rd_i,
  input  logic req_wr_i,
  output logic valid_o,
  output logic grant_o
);

  logic last_grant_q, last_grant_d;

  // On contention favour the channel that did not win last time.
  always_comb begin
    valid_o = en_i & (req_rd_i | req_wr_i);
    if (req_rd_i && req_wr_i) begin
      grant_o = ~last_grant_q;
    end else if (req_wr_i) begin
      grant_o = CH_WR;
    end else begin
      grant_o = CH_RD;
    end
    last_grant_d = valid_o ? grant_o : last_grant_q;
  end

  // Reset to WR so the read channel wins the first contention.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_grant_q <= CH_WR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : accel_mem_port_scheduler
// Description : Shares one Avalon-MM master between the accelerator read and
//               write channels: round-robin arbitration, word-to-byte address
//               conversion, sign-extended write data, waitrequest timeout.
//   AVS_Clk         : clock
//   AVS_Reset       : synchronous active-low reset
//   bus (master)    : RD_*/WR_* core channels and AVM_* Avalon signals
//   Busy            : scheduler not idle
//   Timeout_Err     : sticky waitrequest timeout flag
//   Clear_Err       : clears Timeout_Err (and the perf counters)
//   Perf_Stall_Cnt  : waitrequest stall cycles
//   Perf_Xfer_Cnt   : completed transfers
// Build option: define ACCEL_MEM_PERF_CNT_EN to implement the perf counters;
//               otherwise both counter outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_mem_port_scheduler
  import accel_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         AVS_Clk,
  input  logic                         AVS_Reset,
  accel_mem_port_scheduler_if.master   bus,
  output logic                         Busy,
  output logic                         Timeout_Err,
  input  logic                         Clear_Err,
  output logic [31:0]                  Perf_Stall_Cnt,
  output logic [31:0]                  Perf_Xfer_Cnt
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]           cmd_wdata_q, cmd_wdata_d;
  logic                  ch_q, ch_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TIMEOUT_W-1:0]  w_cnt_inc;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;
  logic                  w_timeout;
  logic                  w_arb_en, w_grant_valid, w_grant_ch;
  logic                  w_in_cmd;
  logic                  w_unused_rdata;

  assign w_arb_en = (state_q == IDLE);
  assign w_in_cmd = (state_q == RD_CMD) || (state_q == WR_CMD);

  rr_arbiter2 u_arb (
    .clk_i    (AVS_Clk),
    .rst_ni   (AVS_Reset),
    .en_i     (w_arb_en),
    .req_rd_i (bus.RD_Req),
    .req_wr_i (bus.WR_Req),
    .valid_o  (w_grant_valid),
    .grant_o  (w_grant_ch)
  );

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ch_d        = ch_q;
    to_cnt_d    = to_cnt_q;
    rd_data_d   = rd_data_q;
    err_d       = err_q;
    w_timeout   = 1'b0;
    w_cnt_inc   = to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (w_grant_valid) begin
          ch_d     = w_grant_ch;
          to_cnt_d = '0;
          if (w_grant_ch == CH_RD) begin
            cmd_addr_d = bus.RD_Addr;
            state_d    = RD_CMD;
          end else begin
            cmd_addr_d  = bus.WR_Addr;
            cmd_wdata_d = 32'($signed(bus.WR_Data));
            state_d     = WR_CMD;
          end
        end
      end
      RD_CMD, WR_CMD: begin
        if (!bus.AVM_waitrequest) begin
          if (state_q == RD_CMD) begin
            rd_data_d = bus.AVM_readdata[DATA_WIDTH-1:0];
          end
          state_d = DONE;
        end else begin
          to_cnt_d = w_cnt_inc;
          // Abort once the stall run reaches the limit; the ack still issues.
          if (w_cnt_inc == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
            w_timeout = 1'b1;
            if (state_q == RD_CMD) begin
              rd_data_d = '0;
            end
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A timeout in the same cycle as Clear_Err leaves the flag set.
    if (w_timeout) begin
      err_d = 1'b1;
    end else if (Clear_Err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge AVS_Clk) begin
    if (!AVS_Reset) begin
      state_q     <= IDLE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ch_q        <= CH_WR;
      to_cnt_q    <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ch_q        <= ch_d;
      to_cnt_q    <= to_cnt_d;
      rd_data_q   <= rd_data_d;
      err_q       <= err_d;
    end
  end

  // Bus outputs decode straight from registered state; address and data are
  // forced to zero outside a command so the idle bus is quiet.
  assign bus.AVM_read       = (state_q == RD_CMD);
  assign bus.AVM_write      = (state_q == WR_CMD);
  assign bus.AVM_address    = w_in_cmd ? word_to_byte(32'(cmd_addr_q)) : 32'd0;
  assign bus.AVM_writedata  = (state_q == WR_CMD) ? cmd_wdata_q : 32'd0;
  assign bus.AVM_byteenable = BYTEENABLE;
  assign bus.RD_Ack         = (state_q == DONE) && (ch_q == CH_RD);
  assign bus.WR_Ack         = (state_q == DONE) && (ch_q == CH_WR);
  assign bus.RD_Data        = rd_data_q;
  assign Busy               = (state_q != IDLE);
  assign Timeout_Err        = err_q;

  // Readdata bits above DATA_WIDTH are intentionally dropped.
  assign w_unused_rdata = ^bus.AVM_readdata;

`ifdef ACCEL_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q, xfer_cnt_q;

  always_ff @(posedge AVS_Clk) begin
    if (!AVS_Reset || Clear_Err) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (w_in_cmd && bus.AVM_waitrequest) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (state_q == DONE) begin
        xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
    end
  end

  assign Perf_Stall_Cnt = stall_cnt_q;
  assign Perf_Xfer_Cnt  = xfer_cnt_q;
`else
  assign Perf_Stall_Cnt = 32'd0;
  assign Perf_Xfer_Cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_mem_port_scheduler
// Description : Self-checking bench for accel_mem_port_scheduler. A small
//               transaction-level model (expected address/data, round-robin
//               order, sticky error, perf counts) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Clear_Err;
  logic        Busy;
  logic        Timeout_Err;
  logic [31:0] Perf_Stall_Cnt;
  logic [31:0] Perf_Xfer_Cnt;

  accel_mem_port_scheduler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

  accel_mem_port_scheduler #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16), .TIMEOUT_W(8), .TIMEOUT_CYCLES(255)
  ) dut (
    .AVS_Clk        (clk),
    .AVS_Reset      (rst_n),
    .bus            (bus),
    .Busy           (Busy),
    .Timeout_Err    (Timeout_Err),
    .Clear_Err      (Clear_Err),
    .Perf_Stall_Cnt (Perf_Stall_Cnt),
    .Perf_Xfer_Cnt  (Perf_Xfer_Cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state
  int          exp_xfer   = 0;
  int          exp_stall  = 0;
  logic [15:0] exp_rdata  = 16'h0;
  bit          last_wr    = 1'b1;  // round-robin history; reset favours read
  bit          perf_valid = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] idx);
    return idx * 32'd4;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [15:0] d);
    int v;
    v = (d >= 16'h8000) ? int'(d) - 65536 : int'(d);
    return 32'(v);
  endfunction

  task automatic check_perf(input string tag);
    if (perf_valid) begin
`ifdef ACCEL_MEM_PERF_CNT_EN
      check({tag, "_xfer"},  Perf_Xfer_Cnt,  64'(exp_xfer));
      check({tag, "_stall"}, Perf_Stall_Cnt, 64'(exp_stall));
`else
      check({tag, "_xfer"},  Perf_Xfer_Cnt,  64'd0);
      check({tag, "_stall"}, Perf_Stall_Cnt, 64'd0);
`endif
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strobes"}, {bus.AVM_read, bus.AVM_write}, 64'd0);
    check({tag, "_acks"},    {bus.RD_Ack, bus.WR_Ack},      64'd0);
    check({tag, "_busy"},    Busy,                          64'd0);
  endtask

  // One transfer from a single requester with `waits` stall cycles.
  task automatic xfer(input bit rd, input logic [31:0] addr, input logic [15:0] data,
                      input int waits, input logic [31:0] rdata);
    bus.RD_Req          = rd;
    bus.WR_Req          = !rd;
    bus.RD_Addr         = addr;
    bus.WR_Addr         = addr;
    bus.WR_Data         = data;
    bus.AVM_waitrequest = 1'b1;
    bus.AVM_readdata    = $urandom;
    tick();  // grant edge
    // Address/data must have been captured at grant
    bus.RD_Addr = $urandom;
    bus.WR_Addr = $urandom;
    bus.WR_Data = 16'($urandom);
    for (int c = 0; c <= waits; c++) begin
      bus.AVM_waitrequest = (c < waits);
      bus.AVM_readdata    = (c < waits) ? $urandom : rdata;
      check("cmd_strobe", {bus.AVM_read, bus.AVM_write}, rd ? 64'd2 : 64'd1);
      check("cmd_addr",   bus.AVM_address, model_addr(addr));
      if (!rd) check("cmd_wdata", bus.AVM_writedata, model_wdata(data));
      check("cmd_noack",  {bus.RD_Ack, bus.WR_Ack}, 64'd0);
      check("cmd_busy",   Busy, 64'd1);
      tick();
    end
    if (rd) exp_rdata = rdata[15:0];
    exp_xfer++;
    exp_stall += waits;
    last_wr = !rd;
    check("done_ack",     {bus.RD_Ack, bus.WR_Ack}, rd ? 64'd2 : 64'd1);
    check("done_strobes", {bus.AVM_read, bus.AVM_write}, 64'd0);
    check("done_rdata",   bus.RD_Data, exp_rdata);
    bus.RD_Req          = 1'b0;
    bus.WR_Req          = 1'b0;
    bus.AVM_waitrequest = 1'b0;
    tick();
    check_idle("post_xfer");
    check("held_rdata", bus.RD_Data, exp_rdata);
    check_perf("post_xfer");
  endtask

  // Read that never sees waitrequest drop; optionally pulse Clear_Err on the
  // abort edge to show the new timeout wins.
  task automatic timeout_read(input bit clear_on_abort);
    bus.RD_Req          = 1'b1;
    bus.RD_Addr         = 32'h40;
    bus.AVM_waitrequest = 1'b1;
    bus.AVM_readdata    = 32'h0000_BEEF;
    tick();
    for (int c = 0; c < 255; c++) begin
      check("to_strobe", bus.AVM_read, 64'd1);
      if (clear_on_abort && c == 254) Clear_Err = 1'b1;
      tick();
    end
    Clear_Err = 1'b0;
    exp_rdata = 16'h0;
    exp_xfer++;
    exp_stall += 255;
    last_wr = 1'b0;
    check("to_done_read", bus.AVM_read, 64'd0);
    check("to_ack",       {bus.RD_Ack, bus.WR_Ack}, 64'd2);
    check("to_rdata",     bus.RD_Data, 64'd0);
    check("to_err",       Timeout_Err, 64'd1);
    bus.RD_Req          = 1'b0;
    bus.AVM_waitrequest = 1'b0;
    tick();
    check_idle("to_idle");
    check("to_err_sticky", Timeout_Err, 64'd1);
  endtask

  task automatic clear_pulse();
    Clear_Err = 1'b1;
    tick();
    Clear_Err = 1'b0;
    exp_xfer   = 0;
    exp_stall  = 0;
    perf_valid = 1'b1;
    check("clr_err", Timeout_Err, 64'd0);
    check_perf("clr");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n               = 1'b0;
    Clear_Err           = 1'b0;
    bus.RD_Req          = 1'b0;
    bus.WR_Req          = 1'b0;
    bus.RD_Addr         = '0;
    bus.WR_Addr         = '0;
    bus.WR_Data         = '0;
    bus.AVM_readdata    = '0;
    bus.AVM_waitrequest = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check_idle("rst");
    check("rst_addr",  bus.AVM_address,    64'd0);
    check("rst_wdata", bus.AVM_writedata,  64'd0);
    check("rst_be",    bus.AVM_byteenable, 64'hF);
    check("rst_rdata", bus.RD_Data,        64'd0);
    check("rst_err",   Timeout_Err,        64'd0);
    check_perf("rst");

    // Directed read and write
    xfer(1'b1, 32'd5, 16'h0, 0, 32'h0000_1234);
    xfer(1'b0, 32'd3, 16'h8001, 4, 32'h0);

    // Timeout, sticky error, read while error set, clear
    timeout_read(1'b0);
    xfer(1'b1, 32'd7, 16'h0, 1, 32'hABCD_5678);
    clear_pulse();

    // Timeout coinciding with Clear_Err
    timeout_read(1'b1);
    perf_valid = 1'b0;
    xfer(1'b1, 32'h3FFF_FFFF, 16'h0, 2, 32'h0000_9ABC);

    // Reset during WR_CMD
    bus.WR_Req          = 1'b1;
    bus.WR_Addr         = 32'd9;
    bus.WR_Data         = 16'h7FFF;
    bus.AVM_waitrequest = 1'b1;
    tick();
    tick();
    check("mid_write", bus.AVM_write, 64'd1);
    rst_n = 1'b0;
    tick();
    exp_rdata  = 16'h0;
    exp_xfer   = 0;
    exp_stall  = 0;
    last_wr    = 1'b1;
    perf_valid = 1'b1;
    check_idle("mid_rst");
    check("mid_rst_rdata", bus.RD_Data, 64'd0);
    check("mid_rst_err",   Timeout_Err, 64'd0);
    check_perf("mid_rst");
    bus.WR_Req          = 1'b0;
    bus.AVM_waitrequest = 1'b0;
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Both requests held: alternating grants starting with read
    bus.RD_Req       = 1'b1;
    bus.WR_Req       = 1'b1;
    bus.RD_Addr      = 32'h11;
    bus.WR_Addr      = 32'h22;
    bus.WR_Data      = 16'hC003;
    bus.AVM_readdata = 32'h0000_0F0F;
    for (int k = 0; k < 4; k++) begin
      bit exp_wr;
      exp_wr = !last_wr;
      tick();
      check("rr_strobe", {bus.AVM_read, bus.AVM_write}, exp_wr ? 64'd1 : 64'd2);
      check("rr_addr",   bus.AVM_address, model_addr(exp_wr ? 32'h22 : 32'h11));
      tick();
      check("rr_ack", {bus.RD_Ack, bus.WR_Ack}, exp_wr ? 64'd1 : 64'd2);
      if (!exp_wr) exp_rdata = 16'h0F0F;
      exp_xfer++;
      last_wr = exp_wr;
      tick();
      check_idle("rr_gap");
    end
    check("rr_rdata", bus.RD_Data, exp_rdata);
    check_perf("rr");
    bus.RD_Req = 1'b0;
    bus.WR_Req = 1'b0;
    tick();
    check_idle("rr_end");

    // Randomized single-channel traffic
    for (int n = 0; n < 24; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, 16'($urandom),
           int'($urandom_range(0, 6)), $urandom);
    end

    // Perf counters: three transfers with 7 stall cycles
    clear_pulse();
    xfer(1'b1, 32'd1, 16'h0,    2, 32'h0000_0001);
    xfer(1'b0, 32'd2, 16'hFFFF, 3, 32'h0);
    xfer(1'b1, 32'd3, 16'h0,    2, 32'h0000_0003);
`ifdef ACCEL_MEM_PERF_CNT_EN
    check("perf_xfer3",  Perf_Xfer_Cnt,  64'd3);
    check("perf_stall7", Perf_Stall_Cnt, 64'd7);
`else
    check("perf_xfer_off",  Perf_Xfer_Cnt,  64'd0);
    check("perf_stall_off", Perf_Stall_Cnt, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
